// File: rtl/ripple_borrow_serial_subtractor.sv
// Bit-serial subtractor: a - b - borrow_in, one bit per clock, LSB first,
// through a single registered borrow stage, with a start/done handshake.
module ripple_borrow_serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             busy_d;
    logic             done_d;
    logic             accept;
    logic             ai;
    logic             bi;
    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;

    // One full-subtractor slice on the current LSBs
    assign ai      = a_sh[0];
    assign bi      = b_sh[0];
    assign d_bit   = ai ^ bi ^ br;
    assign br_nxt  = (~ai & bi) | (~(ai ^ bi) & br);
    assign res_nxt = {d_bit, res[WIDTH-1:1]};
    assign accept  = start && (state != ST_SUB);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_SUB;
            ST_SUB:  if (cnt == CNT_LAST) next_state = ST_DONE;
            ST_DONE: next_state = start ? ST_SUB : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state, registered below
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (next_state)
            ST_SUB:  busy_d = 1'b1;
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Operand shifters, borrow, counter and result; diff/borrow_out only update on the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            br   <= borrow_in;
            cnt  <= '0;
        end else if (state == ST_SUB) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            res  <= res_nxt;
            br   <= br_nxt;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
                diff       <= res_nxt;
                borrow_out <= br_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ripple_borrow_serial_subtractor.sv
// Directed and randomized bench for the bit-serial subtractor at WIDTH=4 and WIDTH=8.
module tb_ripple_borrow_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       bin4, bin8;
    logic [3:0] diff4;
    logic [7:0] diff8;
    logic       bo4, bo8, busy4, busy8, done4, done8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ripple_borrow_serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
        .diff(diff4), .borrow_out(bo4), .busy(busy4), .done(done4)
    );

    ripple_borrow_serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
        .diff(diff8), .borrow_out(bo8), .busy(busy8), .done(done8)
    );

    // Starts one op (caller at a negedge), waits for done with a cycle bound
    task automatic run_op(input bit wide, input logic [7:0] av, input logic [7:0] bv,
                          input logic bin, output logic [7:0] dv, output logic bov,
                          output int lat, output int busy_n, output int overlap);
        if (wide) begin
            a8 = av; b8 = bv; bin8 = bin; start8 = 1'b1;
        end else begin
            a4 = av[3:0]; b4 = bv[3:0]; bin4 = bin; start4 = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        lat = 1;
        busy_n = 0;
        while (!(wide ? done8 : done4) && lat < 40) begin
            busy_n += int'(wide ? busy8 : busy4);
            @(negedge clk);
            lat++;
        end
        dv      = wide ? diff8 : {4'h0, diff4};
        bov     = wide ? bo8 : bo4;
        overlap = int'(wide ? (busy8 & done8) : (busy4 & done4));
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; bin4 = 1'b0;
        a8 = '0; b8 = '0; bin8 = 1'b0;
        @(negedge clk);
        checks++;
        if ({diff4, bo4, busy4, done4} !== 7'b0) begin
            errors++;
            $display("FAIL reset_w4: got diff=%h bo=%b busy=%b done=%b, want all 0", diff4, bo4, busy4, done4);
        end
        checks++;
        if ({diff8, bo8, busy8, done8} !== 11'b0) begin
            errors++;
            $display("FAIL reset_w8: got diff=%h bo=%b busy=%b done=%b, want all 0", diff8, bo8, busy8, done8);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_w4();
        logic [7:0] av [4] = '{8'd9, 8'd3, 8'd0, 8'd15};
        logic [7:0] bv [4] = '{8'd3, 8'd9, 8'd0, 8'd15};
        logic       bi [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] ed [4] = '{4'h6, 4'hA, 4'hF, 4'hF};
        logic       eb [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] dv;
        logic bov;
        int lat, bn, ov;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, av[i], bv[i], bi[i], dv, bov, lat, bn, ov);
            checks++;
            if (dv[3:0] !== ed[i] || bov !== eb[i]) begin
                errors++;
                $display("FAIL basic_w4[%0d]: got diff=%h bo=%b, want diff=%h bo=%b", i, dv[3:0], bov, ed[i], eb[i]);
            end
            checks++;
            if (lat != 5 || bn != 4 || ov != 0) begin
                errors++;
                $display("FAIL timing_w4[%0d]: got lat=%0d busy_cycles=%0d overlap=%0d, want 5 4 0", i, lat, bn, ov);
            end
            checks++;
            if (done4 !== 1'b0 || busy4 !== 1'b0 || diff4 !== ed[i]) begin
                errors++;
                $display("FAIL after_done_w4[%0d]: got done=%b busy=%b diff=%h, want 0 0 %h", i, done4, busy4, diff4, ed[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        logic [3:0] dcap = 4'h0;
        logic bcap = 1'b1;
        a4 = 4'd5; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        a4 = 4'd15; b4 = 4'd15;
        for (int c = 1; c <= 12; c++) begin
            if (done4) begin
                dones++;
                dcap = diff4;
                bcap = bo4;
            end
            if (c == 3) start4 = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (dones != 1 || dcap !== 4'd3 || bcap !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: got dones=%0d diff=%h bo=%b, want 1 3 0", dones, dcap, bcap);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ed;
        logic       eb, edone;
        int bad = 0;
        a4 = 4'd7; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 15; c++) begin
            edone = (c % 5 == 0);
            if (c < 5)       begin ed = 4'd3; eb = 1'b0; end
            else if (c < 10) begin ed = 4'd6; eb = 1'b0; end
            else if (c < 15) begin ed = 4'hA; eb = 1'b1; end
            else             begin ed = 4'd6; eb = 1'b0; end
            checks++;
            if (done4 !== edone || busy4 !== !edone || diff4 !== ed || bo4 !== eb) begin
                errors++;
                bad++;
                $display("FAIL back_to_back c=%0d: got done=%b busy=%b diff=%h bo=%b, want %b %b %h %b",
                         c, done4, busy4, diff4, bo4, edone, !edone, ed, eb);
            end
            if (c == 1) begin a4 = 4'd1; b4 = 4'd7; end
            if (c == 6) begin a4 = 4'd7; b4 = 4'd1; end
            if (c == 15) start4 = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_idle: got done=%b busy=%b, want 0 0", done4, busy4);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] dv;
        logic bov;
        int lat, bn, ov;
        a4 = 4'd2; b4 = 4'd9; bin4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy4 !== 1'b1 || diff4 !== 4'd6) begin
            errors++;
            $display("FAIL pre_reset: got busy=%b diff=%h, want 1 6", busy4, diff4);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || diff4 !== 4'd0 || bo4 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b diff=%h bo=%b, want all 0", busy4, done4, diff4, bo4);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(1'b0, 8'd8, 8'd8, 1'b0, dv, bov, lat, bn, ov);
        checks++;
        if (dv[3:0] !== 4'd0 || bov !== 1'b0 || lat != 5) begin
            errors++;
            $display("FAIL post_reset: got diff=%h bo=%b lat=%0d, want 0 0 5", dv[3:0], bov, lat);
        end
    endtask

    task automatic test_w8();
        logic [7:0] av [3] = '{8'd200, 8'd0,   8'd255};
        logic [7:0] bv [3] = '{8'd55,  8'd255, 8'd0};
        logic       bi [3] = '{1'b1,   1'b0,   1'b1};
        logic [7:0] ed [3] = '{8'd144, 8'd1,   8'd254};
        logic       eb [3] = '{1'b0,   1'b1,   1'b0};
        logic [7:0] dv;
        logic bov;
        int lat, bn, ov;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, av[i], bv[i], bi[i], dv, bov, lat, bn, ov);
            checks++;
            if (dv !== ed[i] || bov !== eb[i] || lat != 9 || bn != 8 || ov != 0) begin
                errors++;
                $display("FAIL w8[%0d]: got diff=%0d bo=%b lat=%0d busy=%0d ov=%0d, want %0d %b 9 8 0",
                         i, dv, bov, lat, bn, ov, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_random_w8();
        logic [7:0] av, bv, dv;
        logic bi, bov;
        logic [8:0] expv;
        int lat, bn, ov;
        for (int i = 0; i < 1000; i++) begin
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            bi = 1'($urandom_range(0, 1));
            expv = 9'(av) - 9'(bv) - 9'(bi);
            run_op(1'b1, av, bv, bi, dv, bov, lat, bn, ov);
            checks++;
            if ({bov, dv} !== expv || lat != 9) begin
                errors++;
                $display("FAIL random_w8[%0d] %0d-%0d-%0d: got bo=%b diff=%0d lat=%0d, want bo=%b diff=%0d lat=9",
                         i, av, bv, bi, bov, dv, lat, expv[8], expv[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_w4();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        test_w8();
        test_random_w8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
